// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: sends a captured pattern MSB-first for a
// programmable number of repetitions, with an optional idle gap between them.
module seq_pattern_gen #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             x,
  output logic             valid,
  output logic             first,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = $clog2(PAT_W);
  localparam int unsigned GAP_W = (GAP > 2) ? $clog2(GAP) : 1;
  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(PAT_W - 1);
  localparam logic [GAP_W-1:0] GapLoad = (GAP > 0) ? GAP_W'(GAP - 1) : '0;
  localparam logic [CNT_W-1:0] RepOne  = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StShift, StGap, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [PAT_W-1:0] r_shift, w_shift_d;
  logic [PAT_W-1:0] r_pat,   w_pat_d;
  logic [CNT_W-1:0] r_rep,   w_rep_d;
  logic [IDX_W-1:0] r_idx,   w_idx_d;
  logic [GAP_W-1:0] r_gap,   w_gap_d;
  logic             w_x_d, w_valid_d, w_first_d, w_busy_d, w_done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state and datapath: the exit decision is taken at rep=1 so rep never wraps.
  always_comb begin
    w_state_d = r_state;
    w_shift_d = r_shift;
    w_pat_d   = r_pat;
    w_rep_d   = r_rep;
    w_idx_d   = r_idx;
    w_gap_d   = r_gap;
    unique case (r_state)
      StIdle: begin
        if (start && (repeat_cnt != '0)) begin
          w_shift_d = pattern;
          w_pat_d   = pattern;
          w_rep_d   = repeat_cnt;
          w_idx_d   = IdxLast;
          w_state_d = StShift;
        end
      end
      StShift: begin
        w_shift_d = r_shift << 1;
        w_idx_d   = r_idx - IDX_W'(1);
        if (r_idx == '0) begin
          if (r_rep == RepOne) begin
            w_state_d = StDone;
          end else if (GAP == 0) begin
            w_rep_d   = r_rep - RepOne;
            w_shift_d = r_pat;
            w_idx_d   = IdxLast;
          end else begin
            w_rep_d   = r_rep - RepOne;
            w_gap_d   = GapLoad;
            w_state_d = StGap;
          end
        end
      end
      StGap: begin
        if (r_gap == '0) begin
          w_shift_d = r_pat;
          w_idx_d   = IdxLast;
          w_state_d = StShift;
        end else begin
          w_gap_d = r_gap - GAP_W'(1);
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_pat   <= '0;
      r_rep   <= '0;
      r_idx   <= '0;
      r_gap   <= '0;
    end else begin
      r_shift <= w_shift_d;
      r_pat   <= w_pat_d;
      r_rep   <= w_rep_d;
      r_idx   <= w_idx_d;
      r_gap   <= w_gap_d;
    end
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    w_x_d     = 1'b0;
    w_valid_d = 1'b0;
    w_first_d = 1'b0;
    w_busy_d  = 1'b0;
    w_done_d  = 1'b0;
    unique case (w_state_d)
      StShift: begin
        w_x_d     = w_shift_d[PAT_W-1];
        w_valid_d = 1'b1;
        w_first_d = (w_idx_d == IdxLast);
        w_busy_d  = 1'b1;
      end
      StGap:   w_busy_d = 1'b1;
      StDone:  w_done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x     <= 1'b0;
      valid <= 1'b0;
      first <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      x     <= w_x_d;
      valid <= w_valid_d;
      first <= w_first_d;
      busy  <= w_busy_d;
      done  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: a queue-based frame model checked every cycle on two
// instances (GAP=0 and GAP=2), plus directed streams with literal expectations.
module tb_seq_pattern_gen;

  localparam int PAT_W = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0, start2 = 1'b0;
  logic [3:0] pat0 = '0, pat2 = '0;
  logic [3:0] rc0 = '0, rc2 = '0;
  logic       x0, valid0, first0, busy0, done0;
  logic       x2, valid2, first2, busy2, done2;

  int tests = 0;
  int fails = 0;

  seq_pattern_gen #(.PAT_W(4), .CNT_W(4), .GAP(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .pattern(pat0), .repeat_cnt(rc0),
    .x(x0), .valid(valid0), .first(first0), .busy(busy0), .done(done0)
  );

  seq_pattern_gen #(.PAT_W(4), .CNT_W(4), .GAP(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .pattern(pat2), .repeat_cnt(rc2),
    .x(x2), .valid(valid2), .first(first2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  // fr marks a cycle that belongs to a frame; o is {x, valid, first, busy, done}.
  typedef struct packed {
    logic       fr;
    logic [4:0] o;
  } exp_t;

  localparam exp_t IdleE = '{fr: 1'b0, o: 5'b00000};

  exp_t q0[$];
  exp_t q2[$];
  exp_t cur0 = '{fr: 1'b0, o: 5'b00000};
  exp_t cur2 = '{fr: 1'b0, o: 5'b00000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int which, input exp_t e);
    if (which == 0) q0.push_back(e);
    else q2.push_back(e);
  endtask

  // Per-cycle expected outputs of a whole accepted frame.
  task automatic build(input int which, input logic [3:0] pat, input int r, input int gap);
    exp_t e;
    for (int i = 0; i < r; i++) begin
      for (int b = PAT_W - 1; b >= 0; b--) begin
        e.fr = 1'b1;
        e.o  = {pat[b], 1'b1, (b == PAT_W - 1), 1'b1, 1'b0};
        push(which, e);
      end
      if (i < r - 1) begin
        for (int g = 0; g < gap; g++) begin
          e.fr = 1'b1;
          e.o  = 5'b00010;
          push(which, e);
        end
      end
    end
    e.fr = 1'b1;
    e.o  = 5'b00001;
    push(which, e);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q0.delete();
        q2.delete();
        cur0 = IdleE;
        cur2 = IdleE;
      end else begin
        if (!cur0.fr && start0 && rc0 != 4'd0) build(0, pat0, int'(rc0), 0);
        if (!cur2.fr && start2 && rc2 != 4'd0) build(1, pat2, int'(rc2), 2);
        cur0 = (q0.size() > 0) ? q0.pop_front() : IdleE;
        cur2 = (q2.size() > 0) ? q2.pop_front() : IdleE;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("model_dut0", {27'b0, x0, valid0, first0, busy0, done0}, {27'b0, cur0.o});
      check("model_dut2", {27'b0, x2, valid2, first2, busy2, done2}, {27'b0, cur2.o});
    end
  end

  initial begin
    logic [7:0]  xs, fs, vs;
    logic [15:0] xs16, vs16, bs16;
    int          cnt;
    logic        seen;

    repeat (2) @(negedge clk);
    check("reset_outputs", {27'b0, x0, valid0, first0, busy0, done0}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 0110 x2, back-to-back
    start0 = 1'b1; pat0 = 4'b0110; rc0 = 4'd2;
    xs = '0; fs = '0; vs = '0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 0) start0 = 1'b0;
      if (k < 8) begin
        xs = {xs[6:0], x0}; fs = {fs[6:0], first0}; vs = {vs[6:0], valid0};
      end else begin
        check("t1_done", {31'b0, done0}, 32'd1);
      end
    end
    check("t1_x", {24'b0, xs}, {24'b0, 8'b0110_0110});
    check("t1_first", {24'b0, fs}, {24'b0, 8'b1000_1000});
    check("t1_valid", {24'b0, vs}, 32'h0000_00FF);
    repeat (2) @(negedge clk);

    // 1010 x3 with a 2-cycle gap
    start2 = 1'b1; pat2 = 4'b1010; rc2 = 4'd3;
    xs16 = '0; vs16 = '0; bs16 = '0;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (k == 0) start2 = 1'b0;
      if (k < 16) begin
        xs16 = {xs16[14:0], x2}; vs16 = {vs16[14:0], valid2}; bs16 = {bs16[14:0], busy2};
      end else begin
        check("t2_done_end", {30'b0, done2, busy2}, 32'd2);
      end
    end
    check("t2_x", {16'b0, xs16}, {16'b0, 16'b1010_0010_1000_1010});
    check("t2_valid", {16'b0, vs16}, {16'b0, 16'b1111_0011_1100_1111});
    check("t2_busy", {16'b0, bs16}, 32'h0000_FFFF);
    repeat (2) @(negedge clk);

    // Zero repeat count is ignored
    start0 = 1'b1; pat0 = 4'b1111; rc0 = 4'd0;
    repeat (3) @(negedge clk);
    check("t3_idle", {29'b0, busy0, valid0, done0}, 32'd0);
    start0 = 1'b0;
    @(negedge clk);

    // Input changes and start pulses during the frame have no effect
    start0 = 1'b1; pat0 = 4'b1001; rc0 = 4'd2;
    xs = '0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k < 8) xs = {xs[6:0], x0};
      else check("t4_done", {31'b0, done0}, 32'd1);
      if (k < 7) begin
        start0 = ~start0 | k[0];
        pat0   = 4'($urandom);
        rc0    = 4'($urandom);
      end else begin
        start0 = 1'b0;
      end
    end
    check("t4_x", {24'b0, xs}, {24'b0, 8'b1001_1001});
    repeat (4) @(negedge clk);

    // Asynchronous reset mid-frame
    start0 = 1'b1; pat0 = 4'b1111; rc0 = 4'd3;
    @(negedge clk);
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("t5_async_reset", {27'b0, x0, valid0, first0, busy0, done0}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    start0 = 1'b1; pat0 = 4'b0110; rc0 = 4'd1;
    xs = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) start0 = 1'b0;
      if (k < 4) xs = {xs[6:0], x0};
      else check("t5_done_after", {31'b0, done0}, 32'd1);
    end
    check("t5_x_after", {28'b0, xs[3:0]}, 32'h6);
    repeat (2) @(negedge clk);

    // Maximum repeat count
    start0 = 1'b1; pat0 = 4'b1011; rc0 = 4'hF;
    cnt = 0; seen = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (k == 0) start0 = 1'b0;
      if (valid0) cnt++;
      if (done0) begin
        seen = 1'b1;
        break;
      end
    end
    check("t6_done_seen", {31'b0, seen}, 32'd1);
    check("t6_valid_count", 32'(cnt), 32'd60);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial bit-pattern transmitter, the source side of the FSM sequence-detector link. On a start request it captures a PAT_W-bit pattern and a repeat count, then drives the pattern MSB-first onto a 1-bit serial line, one bit per clock, for the requested number of repetitions. An optional idle gap can be inserted between repetitions. It is used to generate stimulus streams for the Moore/Mealy sequence detectors and as a standalone serial pattern source.

## Interface
Parameters:
- PAT_W, 4, pattern width in bits (≥2)
- CNT_W, 4, repeat-count width
- GAP, 0, idle cycles inserted between consecutive repetitions (0 = back-to-back)

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- pattern  in  PAT_W  pattern to send; bit PAT_W-1 goes first
- repeat_cnt  in  CNT_W  number of repetitions; 0 = request ignored
- x  out  1  serial data (registered)
- valid  out  1  x carries a pattern bit this cycle
- first  out  1  high on bit PAT_W-1 of each repetition
- busy  out  1  high in SHIFT and GAP
- done  out  1  one-cycle pulse after the final bit

## Operation
- States: IDLE, SHIFT, GAP, DONE. The state register and all outputs are registered (Moore).
- Reset (rst_n=0, at any time, including mid-frame): state=IDLE immediately. x=0, valid=0, first=0, busy=0, done=0. Shift, bit-index and repeat registers are cleared.
- IDLE:
  - If start=1 and repeat_cnt≠0 at an edge: load shift_reg←pattern, rep←repeat_cnt, bit_idx←PAT_W-1, then go to SHIFT.
  - If start=1 and repeat_cnt=0: stay in IDLE; no done pulse.
- SHIFT: x=shift_reg[PAT_W-1] and valid=1. Each edge shifts left by one and decrements bit_idx. When bit_idx=0, the repetition is complete:
  - If rep=1: go to DONE.
  - Else if GAP=0: rep←rep-1, reload shift_reg←captured pattern, bit_idx←PAT_W-1, stay in SHIFT. Output is continuous with no bubble.
  - Else: rep←rep-1, gap counter←GAP-1, go to GAP.
- GAP: x=0, valid=0, busy=1. When the gap counter reaches 0, reload the pattern and go to SHIFT.
- DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE unconditionally.
- pattern and repeat_cnt are captured only at the accepting edge. Later changes to these inputs have no effect on the frame in progress.
- start is ignored in SHIFT, GAP and DONE. Requests are not queued.
- In IDLE, DONE and GAP, x is held at 0.

## Timing
- start accepted at edge T: the first bit is on x with valid=first=busy=1 during cycle T+1.
- Total valid cycles = PAT_W·R, where R is the captured repeat count.
- Total gap cycles = GAP·(R-1).
- done is high in the cycle immediately after the last valid bit.
- Minimum spacing between accepted starts = PAT_W·R + GAP·(R-1) + 2 cycles.
- With R = 2^CNT_W−1 (max), there is no counter wrap. rep never underflows, because the exit decision is taken at rep=1.

## Test plan
- Reset then start with pattern=4'b0110, repeat_cnt=2, GAP=0 → x=0,1,1,0,0,1,1,0 over 8 consecutive cycles with valid=1 throughout. first is high on cycles 1 and 5. done pulses on cycle 9. A seq_detector_0110 on x must assert z twice.
- pattern=4'b1010, repeat_cnt=3, GAP=2 → 1010, then 2 cycles with valid=0 and x=0, then 1010, then a 2-cycle gap, then 1010. busy stays high through all 16 cycles. done pulses once.
- start with repeat_cnt=0 → state remains IDLE, and busy, valid and done all stay 0.
- Change pattern and pulse start repeatedly during SHIFT → the transmitted stream is unchanged and no second frame follows done.
- Assert rst_n=0 asynchronously mid-frame (between clock edges) → x, valid, busy and first drop to 0 without waiting for a clock edge, and no done pulse occurs. After release, a new start behaves normally.
- Max count: repeat_cnt=4'hF, GAP=0 → exactly 60 valid cycles, then a single done pulse.
